// File: rtl/load_align_unit.sv
// Load stage: issues a word-aligned memory read, picks the addressed byte/halfword
// (little-endian), extends it to 32 bits and hands it to write-back as a one-cycle strobe.
module load_align_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct,
  input  logic [31:0] addr,
  input  logic [4:0]  rt_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        load_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic             TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_capture;
  logic [1:0]       r_off_q;
  logic [2:0]       r_funct_q;
  logic [4:0]       r_rt_q;

  function automatic logic f_load_bad(input logic [2:0] f, input logic [1:0] off);
    case (f)
      3'b000, 3'b100: f_load_bad = 1'b0;
      3'b001, 3'b101: f_load_bad = off[0];
      3'b010:         f_load_bad = (off != 2'b00);
      default:        f_load_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rdata[31:16] : rdata[15:0];
    case (f)
      3'b000:  f_extend = {{24{b[7]}}, b};
      3'b001:  f_extend = {{16{h[15]}}, h};
      3'b010:  f_extend = rdata;
      3'b100:  f_extend = {24'd0, b};
      3'b101:  f_extend = {16'd0, h};
      default: f_extend = 32'd0;
    endcase
  endfunction

  // Next-state and timeout-counter logic
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = {CNT_W{1'b0}};
        if (start) begin
          w_capture    = 1'b1;
          w_next_state = f_load_bad(funct, addr[1:0]) ? S_ERR : S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        // ack beats a timeout landing in the same cycle
        if (mem_ack) begin
          w_next_state = S_WB;
          w_cnt_next   = {CNT_W{1'b0}};
        end else if (TO_EN && ((r_cnt + CNT_W'(1)) == TO_VAL)) begin
          w_next_state = S_ERR;
          w_cnt_next   = {CNT_W{1'b0}};
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        w_next_state = S_IDLE;
        w_cnt_next   = {CNT_W{1'b0}};
      end
      S_ERR: begin
        w_next_state = S_IDLE;
        w_cnt_next   = {CNT_W{1'b0}};
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_off_q   <= 2'b00;
      r_funct_q <= 3'b000;
      r_rt_q    <= 5'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      busy      <= 1'b0;
      wb_en     <= 1'b0;
      wb_reg    <= 5'd0;
      wb_data   <= 32'd0;
      load_err  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      mem_req  <= (w_next_state == S_REQ);
      busy     <= (w_next_state != S_IDLE);
      wb_en    <= (w_next_state == S_WB) && (r_rt_q != 5'd0);
      load_err <= (w_next_state == S_ERR);
      if (w_capture) begin
        r_off_q   <= addr[1:0];
        r_funct_q <= funct;
        r_rt_q    <= rt_addr;
        mem_addr  <= {addr[31:2], 2'b00};
      end
      if (w_next_state == S_WB) begin
        wb_reg <= r_rt_q;
      end
      if ((r_state == S_REQ) && mem_ack) begin
        wb_data <= f_extend(r_funct_q, r_off_q, mem_rdata);
      end
    end
  end

endmodule
